// File: rtl/diff_demo_pkg.sv
// Shared diff-core definitions: default geometry, FM word layout and bank-swap FSM states.
package diff_demo_pkg;

    localparam int CONF_PE_COL       = 8;
    localparam int CONF_FM_BUF_DEPTH = 256;
    localparam int CONF_FM_DATA_W    = 8;
    localparam int CONF_FM_GUARD_W   = 6;
    localparam int CONF_FM_WORD_W    = CONF_FM_DATA_W + CONF_FM_GUARD_W;

    typedef struct packed {
        logic [CONF_FM_DATA_W-1:0]  data;
        logic [CONF_FM_GUARD_W-1:0] guard;
    } fm_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } bank_fsm_e;

endpackage

// File: rtl/fm_bank_pair.sv
// One PE column's ping-pong FM/guard banks with registered read-out.
// DIFF_FM_ZERO_FLAG_EN adds per-bank nonzero-data tracking for the rd_zero output.
module fm_bank_pair #(
    parameter int DATA_W  = 8,
    parameter int GUARD_W = 6,
    parameter int DEPTH   = 256,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_sel,
    input  logic               swap,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [GUARD_W-1:0] wguard,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [DATA_W-1:0]  rdata,
    output logic [GUARD_W-1:0] rguard,
    output logic               rvalid,
    output logic               rd_zero
);

    localparam int W = DATA_W + GUARD_W;

    logic [1:0][W-1:0] bank_q;
    logic [W-1:0]      rword;

    // The write side is always the bank not currently selected for reads.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        two_port_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
            .clk   (clk),
            .we    (we && (rd_sel != 1'(b))),
            .waddr (waddr),
            .wdata ({wdata, wguard}),
            .raddr (raddr),
            .rdata (bank_q[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rword  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) rword <= bank_q[rd_sel];
        end
    end

    assign {rdata, rguard} = rword;

`ifdef DIFF_FM_ZERO_FLAG_EN
    logic [1:0] nz;
    logic       zero_q;
    logic       wr_nz;

    assign wr_nz = we && (wdata != '0);

    // The outgoing write bank becomes the read side; include a write landing on the swap edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            nz     <= '0;
            zero_q <= 1'b0;
        end else begin
            if (wr_nz) nz[~rd_sel] <= 1'b1;
            if (swap) begin
                nz[rd_sel] <= 1'b0;
                zero_q     <= !(nz[~rd_sel] || wr_nz);
            end
        end
    end

    assign rd_zero = zero_q;
`else
    logic unused_swap;
    assign unused_swap = swap;
    assign rd_zero     = 1'b0;
`endif

endmodule

// File: rtl/two_port_mem.sv
// Simple dual-port word store: one synchronous write port, one combinational read port.
module two_port_mem #(
    parameter int W     = 14,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/diff_fm_pingpong_bank.sv
// Per-column ping-pong FM/guard buffer bank with loader, write-back and swap handshake.
// Optional zero-column flags under DIFF_FM_ZERO_FLAG_EN.
module diff_fm_pingpong_bank
    import diff_demo_pkg::*;
#(
    parameter int NUM_COL = CONF_PE_COL,
    parameter int DATA_W  = CONF_FM_DATA_W,
    parameter int GUARD_W = CONF_FM_GUARD_W,
    parameter int DEPTH   = CONF_FM_BUF_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_COL-1:0]                ld_en,
    input  logic [NUM_COL-1:0][AW-1:0]        ld_addr,
    input  logic [NUM_COL-1:0][DATA_W-1:0]    ld_data,
    input  logic [NUM_COL-1:0][GUARD_W-1:0]   ld_guard,
    input  logic                              wb_valid,
    output logic                              wb_ready,
    input  logic [CW-1:0]                     wb_col,
    input  logic [DATA_W-1:0]                 wb_data,
    input  logic [GUARD_W-1:0]                wb_guard,
    input  logic [NUM_COL-1:0]                rd_en,
    output logic                              rd_ready,
    input  logic [NUM_COL-1:0][AW-1:0]        rd_addr,
    output logic [NUM_COL-1:0][DATA_W-1:0]    rd_data,
    output logic [NUM_COL-1:0][GUARD_W-1:0]   rd_guard,
    output logic [NUM_COL-1:0]                rd_valid,
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic [NUM_COL-1:0][AW:0]          fill_level,
    output logic [NUM_COL-1:0]                rd_col_zero
);

    bank_fsm_e state, state_nxt;
    logic      rd_sel;
    logic      armed;

    logic [NUM_COL-1:0][AW:0] wb_cnt;
    logic [NUM_COL-1:0]       col_hit, col_open, wb_fire;

    always_comb begin
        state_nxt = state;
        rd_ready  = 1'b0;
        case (state)
            IDLE: begin
                rd_ready = 1'b1;
                if (swap_req && armed) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = SWAP;
            SWAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // armed blocks a request still held high from the previous swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_sel   <= 1'b0;
            armed    <= 1'b1;
            swap_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            swap_ack <= (state == SWAP);
            if (state == SWAP) begin
                rd_sel <= ~rd_sel;
                armed  <= 1'b0;
            end else if (!swap_req) begin
                armed  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cnt     <= '0;
            fill_level <= '0;
        end else if (state == SWAP) begin
            fill_level <= wb_cnt;
            wb_cnt     <= '0;
        end else begin
            for (int c = 0; c < NUM_COL; c++)
                if (wb_fire[c]) wb_cnt[c] <= wb_cnt[c] + (AW+1)'(1);
        end
    end

    // An out-of-range wb_col matches no column, so wb_ready stays low for it.
    assign wb_ready = (state != SWAP) && |(col_hit & col_open);

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        assign col_hit[c]  = (wb_col == CW'(c));
        assign col_open[c] = (wb_cnt[c] != (AW+1)'(DEPTH)) && !ld_en[c];
        assign wb_fire[c]  = wb_valid && wb_ready && col_hit[c];

        fm_bank_pair #(.DATA_W(DATA_W), .GUARD_W(GUARD_W), .DEPTH(DEPTH)) u_pair (
            .clk     (clk),
            .rst     (rst),
            .rd_sel  (rd_sel),
            .swap    (state == SWAP),
            .we      (ld_en[c] || wb_fire[c]),
            .waddr   (ld_en[c] ? ld_addr[c]  : wb_cnt[c][AW-1:0]),
            .wdata   (ld_en[c] ? ld_data[c]  : wb_data),
            .wguard  (ld_en[c] ? ld_guard[c] : wb_guard),
            .re      (rd_en[c] && rd_ready),
            .raddr   (rd_addr[c]),
            .rdata   (rd_data[c]),
            .rguard  (rd_guard[c]),
            .rvalid  (rd_valid[c]),
            .rd_zero (rd_col_zero[c])
        );
    end

endmodule

// File: doc/diff_fm_pingpong_bank.md
Name: diff_fm_pingpong_bank

Overview:
- Parametrised successor of the per-column fixed-size FM and guard buffers in the diff core.
- One ping-pong buffer pair per PE column. Each word holds feature-map data plus its guard bits.
- Write side is fed by the external loader and by PE-row write-back, with per-column auto-increment addressing. Read side serves the PE columns.
- A bank-swap handshake exchanges the two sides between layers.

Parameters:
NUM_COL, 8, number of PE columns / buffer pairs
DATA_W, 8, feature-map word width
GUARD_W, 6, guard-map word width
DEPTH, 256, words per bank per column; power of two, >= 4
AW, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_en  in  NUM_COL  loader write strobe per column (write-side bank)
ld_addr  in  NUM_COL x AW  loader address
ld_data  in  NUM_COL x DATA_W  loader FM data
ld_guard  in  NUM_COL x GUARD_W  loader guard data
wb_valid  in  1  write-back word valid
wb_ready  out  1  write-back accept
wb_col  in  $clog2(NUM_COL)  target column of write-back word
wb_data  in  DATA_W  write-back FM data
wb_guard  in  GUARD_W  write-back guard data
rd_en  in  NUM_COL  read strobe per column (read-side bank)
rd_ready  out  1  read side accepting strobes
rd_addr  in  NUM_COL x AW  read address
rd_data  out  NUM_COL x DATA_W  read data, registered
rd_guard  out  NUM_COL x GUARD_W  read guard, registered
rd_valid  out  NUM_COL  rd_data/rd_guard valid
swap_req  in  1  request bank swap (level, held until ack)
swap_ack  out  1  one-cycle pulse: swap performed
fill_level  out  NUM_COL x (AW+1)  write-back word count of current read-side bank, latched at swap
rd_col_zero  out  NUM_COL  read-side bank of column holds no nonzero data (optional feature)

Behaviour:
- Clocking: all state on rising clk. rst is synchronous and active-high.
- Reset values:
  - rd_sel=0 (bank0 read, bank1 write); FSM=IDLE.
  - wb_cnt[c]=0; fill_level=0; rd_valid=0; rd_data=0; rd_guard=0; swap_ack=0; rd_col_zero=0.
  - Memory contents not cleared.
  - Reset mid-operation aborts any swap and in-flight read; rd_valid=0 next cycle.
- Read path:
  - Strobe accepted when rd_en[c] && rd_ready.
  - rd_data/rd_guard/rd_valid[c] appear exactly 1 cycle later, from the bank selected at accept time.
  - rd_valid[c] is a one-cycle pulse per accepted strobe.
  - rd_data holds its value when no read.
- Loader writes: ld_en[c] writes {ld_data, ld_guard} at ld_addr[c] in the write-side bank. Accepted in every FSM state.
- Write-back:
  - wb_ready = (state!=SWAP) && (wb_cnt[wb_col] != DEPTH) && !ld_en[wb_col].
  - The loader wins a same-column collision.
  - On wb_valid && wb_ready: write at address wb_cnt[wb_col] in the write-side bank; wb_cnt[wb_col] increments.
  - Full at DEPTH: no wrap, wb_ready=0.
  - Out-of-range wb_col (>= NUM_COL): wb_ready=0.
- FSM:
  - IDLE: rd_ready=1. swap_req -> DRAIN.
  - DRAIN: rd_ready=0. Lasts exactly 1 cycle so any read accepted in the previous cycle returns from the old bank. -> SWAP.
  - SWAP: rd_ready=0, wb_ready=0. Next edge: rd_sel toggles, fill_level[c] <= wb_cnt[c], wb_cnt <= 0, swap_ack=1 for that one cycle. -> IDLE.
- Handshake rules:
  - swap_req still high in the ack cycle is ignored; a new swap needs swap_req low for >= 1 cycle.
  - Swap latency from swap_req rise: ack 3 cycles later.

Optional Feature:
- Macro: DIFF_FM_ZERO_FLAG_EN.
- With the macro:
  - Per column and bank, a nz flag sets on any write (loader or write-back) whose data is nonzero.
  - At swap, the new write-side bank's flags clear.
  - rd_col_zero[c] = !nz[rd_sel][c], used by the PE controller to skip all-zero diff columns.
- Without the macro: flags are not instantiated; rd_col_zero tied to 0.

Decomposition:
- Shared package diff_demo_pkg gains:
  - CONF_FM_WORD_W = DATA_W + GUARD_W.
  - A packed struct fm_word_t {data, guard}.
  - An enum bank_fsm_e {IDLE, DRAIN, SWAP}.
- Existing CONF_PE_COL and CONF_FM_BUF_DEPTH supply the defaults.
- Sub-module: fm_bank_pair, one column's two two_port_mem banks plus read/write bank muxing, instantiated NUM_COL times by generate.

Test Plan:
- Reset then read: rst high 2 cycles; rd_en[0]=1 addr 0 -> rd_valid[0]=1 one cycle later; swap_ack=0, fill_level=0.
- Write-back ordering: push 3 words 0x11,0x22,0x33 to col 2; swap_req -> swap_ack 3 cycles later; fill_level[2]=3; reads of addr 0,1,2 return 0x11,0x22,0x33 one cycle each.
- Collision and full: ld_en[1] same cycle as wb_valid with wb_col=1 -> wb_ready=0, loader word written. Fill col 1 to DEPTH=256 -> wb_ready=0; no overwrite of addr 0.
- Read across swap: rd_en in the IDLE cycle preceding DRAIN -> data from old bank; rd_ready=0 in DRAIN/SWAP; first read after ack returns new bank.
- Reset mid-swap: rst asserted during DRAIN -> FSM IDLE, rd_sel unchanged, no swap_ack.
- DIFF_FM_ZERO_FLAG_EN: load only zeros to col 0 and one 0x05 to col 1, swap -> rd_col_zero[0]=1, rd_col_zero[1]=0. Without the macro, both 0.
